inst_d: RTL and testbench
=========================

# inst_d

Instruction decode stage with an integrated IF/ID pipeline register and 32×32 register file. It sits directly downstream of the instruction fetch stage.
- Captures `instruction` and the fetch PC each cycle, unless stalled or flushed.
- Decodes opcode, register fields and sign-extended immediate, and reads both source operands.
- Drives the `rs/rt/rd_f_id`, `id_dest` and `reg_write_f_id` hazard inputs back to fetch.
- Accepts the write-back port from the final stage.

## Interface
Parameters:
- `NREG`, 32, number of architectural registers; r0 reads zero.
- `IMM_W`, 16, immediate field width before sign extension to 32.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `instruction` in 32: fetched word.
- `pc_in` in 32: PC of the fetched word.
- `stall` in 1: hold the IF/ID register; do not capture.
- `flush` in 1: replace the next captured word with a bubble. Has priority over `stall`.
- `wb_en` in 1: register-file write enable.
- `wb_dest` in 5: write-back register index.
- `wb_data` in 32: write-back data.
- `rs_f_id` out 5: rs field, `[25:21]`.
- `rt_f_id` out 5: rt field, `[20:16]`.
- `rd_f_id` out 5: rd field, `[15:11]`. Zero for I-type.
- `id_dest` out 5: destination register of the decoded instruction.
- `reg_write_f_id` out 1: the decoded instruction writes `id_dest`.
- `opcode_id` out 6: `[31:26]` of the decoded word.
- `rs_val` out 32: register-file read of rs.
- `rt_val` out 32: register-file read of rt.
- `imm_ext` out 32: sign-extended `[15:0]`.
- `pc_id` out 32: PC of the decoded instruction.
- `mem_read` out 1: asserted for LDW.
- `mem_write` out 1: asserted for STW.
- `valid_id` out 1: the decoded slot holds a real instruction.
- `halt_id` out 1: sticky; HALT has been decoded.

## Operation
Opcode map:
- ADD 000000, ADDI 000001, SUB 000010, SUBI 000011
- MUL 000100, MULI 000101, OR 000110, ORI 000111
- AND 001000, ANDI 001001, XOR 001010, XORI 001011
- LDW 001100, STW 001101, BZ 001110, BEQ 001111, JR 010000, HALT 010001

Write classes:
- R-type (ADD, SUB, MUL, OR, AND, XOR): `id_dest` = rd, `reg_write_f_id` = 1.
- I-type arithmetic/logic and LDW: `id_dest` = rt, `reg_write_f_id` = 1.
- STW, BZ, BEQ, JR, HALT: `reg_write_f_id` = 0, `id_dest` = 0.
- Undefined opcodes: treated as bubbles. `valid_id` = 1, but all write, memory and halt flags are 0.

`reg_write_f_id` is additionally gated by `valid_id`. When `id_dest` = 0, `reg_write_f_id` is forced to 0, so writes to r0 never create hazards.

IF/ID register states (a two-state FSM: RUN, HALTED):
- RUN, `flush`=1: capture bubble (`valid_id`=0, instruction 0, `pc_id` 0).
- RUN, `stall`=1, `flush`=0: hold.
- RUN, otherwise: capture `instruction` and `pc_in`, `valid_id`=1.
- A valid HALT in the IF/ID register moves the FSM to HALTED on the next edge and sets `halt_id`.
- In HALTED, captures are suppressed: `valid_id`=0, `halt_id`=1 until reset.

Register file:
- Written on the rising edge when `wb_en` is set and `wb_dest` != 0.
- r0 always reads 0.
- Reads are combinational from the current IF/ID fields.

Reset (rst=0, asynchronous):
- IF/ID cleared, `valid_id`=0, `halt_id`=0, FSM=RUN, all registers 0.
- Every output is 0 during reset.
- Reset asserted mid-stall or while HALTED returns the block to RUN with an empty slot.

## Timing
- Word presented on `instruction` in cycle N appears on all decode outputs in cycle N+1.
- `stall` in cycle N keeps the cycle-N outputs in N+1.
- `flush` in cycle N makes `valid_id`=0 in N+1.
- A write-back committed at edge N is visible on `rs_val`/`rt_val` from cycle N+1.
- Same-cycle write and read of the same register: see Configuration.
- A stall and a write-back may coincide. The held instruction re-reads and sees the updated value in the next cycle.

## Configuration
`ID_WB_BYPASS_EN`:
- Defined: when `wb_en` && `wb_dest` != 0 && `wb_dest` matches rs (or rt), `rs_val` (or `rt_val`) returns `wb_data` combinationally in the same cycle.
- Undefined: the old register value is returned in that cycle, and the hazard stall in fetch covers the gap.

## Structure
- Opcode constants go in the shared package in `struct.sv` as a 6-bit enum `opcode_t`.
- The shared package also holds the field slices (rs/rt/rd/imm bit positions) and a `NOP_WORD` constant.
- The register file is the one sub-module: `reg_file` (two read ports, one write port, r0 hardwired zero, optional bypass under the macro).
- The IF/ID register, FSM and decode logic stay in `inst_d`.

## Test plan
- Reset, then present ADD r3,r1,r2 (0x00221800) → next cycle: `rs_f_id`=1, `rt_f_id`=2, `id_dest`=3, `reg_write_f_id`=1, `valid_id`=1.
- Write back r5=0xDEADBEEF, then decode ADDI r6,r5,-4 (0x04A6FFFC) → `rs_val`=0xDEADBEEF, `imm_ext`=0xFFFFFFFC, `id_dest`=6.
- Hold `stall` for 3 cycles while `instruction` changes → outputs unchanged throughout. Assert `stall`+`flush` together → `valid_id`=0 and `reg_write_f_id`=0 next cycle.
- Write-back to r0 with data 0x1234 → `rs_val` for rs=0 stays 0 and `reg_write_f_id`=0 for any `id_dest`=0.
- Decode HALT (0x44000000) → `halt_id`=1 one cycle later, `valid_id`=0 for all further words. Pulse `rst`=0 → all outputs 0, decode resumes.
- Same-cycle write r7=0x55 and decode STW reading r7 → `rt_val`=0x55 when `ID_WB_BYPASS_EN` is defined, old value otherwise.

Source files
------------

// File: rtl/inst_d_pkg.sv
// Shared decode definitions for the instruction decode stage: opcode map,
// instruction field positions, write classes and IF/ID FSM states.
package inst_d_pkg;

  typedef enum logic [5:0] {
    OpAdd  = 6'b000000,
    OpAddi = 6'b000001,
    OpSub  = 6'b000010,
    OpSubi = 6'b000011,
    OpMul  = 6'b000100,
    OpMuli = 6'b000101,
    OpOr   = 6'b000110,
    OpOri  = 6'b000111,
    OpAnd  = 6'b001000,
    OpAndi = 6'b001001,
    OpXor  = 6'b001010,
    OpXori = 6'b001011,
    OpLdw  = 6'b001100,
    OpStw  = 6'b001101,
    OpBz   = 6'b001110,
    OpBeq  = 6'b001111,
    OpJr   = 6'b010000,
    OpHalt = 6'b010001
  } opcode_t;

  localparam int unsigned OpcHi = 31;
  localparam int unsigned OpcLo = 26;
  localparam int unsigned RsHi  = 25;
  localparam int unsigned RsLo  = 21;
  localparam int unsigned RtHi  = 20;
  localparam int unsigned RtLo  = 16;
  localparam int unsigned RdHi  = 15;
  localparam int unsigned RdLo  = 11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {WrNone, WrRd, WrRt} wr_class_e;

  typedef enum logic [0:0] {StRun, StHalted} id_state_e;

  // Which field (if any) names the destination; undefined opcodes fall to WrNone.
  function automatic wr_class_e wr_class(logic [5:0] op);
    case (op)
      OpAdd, OpSub, OpMul, OpOr, OpAnd, OpXor:                 return WrRd;
      OpAddi, OpSubi, OpMuli, OpOri, OpAndi, OpXori, OpLdw:    return WrRt;
      default:                                                 return WrNone;
    endcase
  endfunction

endpackage

// File: rtl/inst_d_if.sv
// Fetch/write-back <-> decode signal bundle. master = upstream fetch and
// write-back side, slave = the decode stage.
interface inst_d_if;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  logic [4:0]  rs_f_id;
  logic [4:0]  rt_f_id;
  logic [4:0]  rd_f_id;
  logic [4:0]  id_dest;
  logic        reg_write_f_id;
  logic [5:0]  opcode_id;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] pc_id;
  logic        mem_read;
  logic        mem_write;
  logic        valid_id;
  logic        halt_id;

  modport master (
    output instruction, pc_in, stall, flush, wb_en, wb_dest, wb_data,
    input  rs_f_id, rt_f_id, rd_f_id, id_dest, reg_write_f_id, opcode_id, rs_val, rt_val,
           imm_ext, pc_id, mem_read, mem_write, valid_id, halt_id
  );

  modport slave (
    input  instruction, pc_in, stall, flush, wb_en, wb_dest, wb_data,
    output rs_f_id, rt_f_id, rd_f_id, id_dest, reg_write_f_id, opcode_id, rs_val, rt_val,
           imm_ext, pc_id, mem_read, mem_write, valid_id, halt_id
  );
endinterface

// File: rtl/reg_file.sv
// 2-read/1-write register file, r0 hardwired to zero, cleared on reset.
// Define ID_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regs_q [NREG];
  logic        wr_ok;

  assign wr_ok = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
`ifdef ID_WB_BYPASS_EN
    if (wr_ok && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_ok && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/inst_d.sv
// Decode stage: IF/ID pipeline register with RUN/HALTED FSM, field decode and
// operand read. Same-cycle write-back forwarding is selected by ID_WB_BYPASS_EN.
module inst_d
  import inst_d_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  inst_d_if.slave  id_io
);

  id_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic [5:0]  op;
  logic [4:0]  rs_fld, rt_fld, rd_fld;
  logic        halt_dec;
  wr_class_e   cls;
  logic [31:0] rs_rdata, rt_rdata;

  assign op       = instr_q[OpcHi:OpcLo];
  assign rs_fld   = instr_q[RsHi:RsLo];
  assign rt_fld   = instr_q[RtHi:RtLo];
  assign rd_fld   = instr_q[RdHi:RdLo];
  assign cls      = wr_class(op);
  assign halt_dec = valid_q && (op == OpHalt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (state_q)
      StRun: begin
        // A decoded HALT wins over stall/flush: the slot empties as we stop.
        if (halt_dec || id_io.flush) begin
          state_d = halt_dec ? StHalted : StRun;
          instr_d = NOP_WORD;
          pc_d    = '0;
          valid_d = 1'b0;
        end else if (!id_io.stall) begin
          instr_d = id_io.instruction;
          pc_d    = id_io.pc_in;
          valid_d = 1'b1;
        end
      end
      StHalted: begin
        instr_d = NOP_WORD;
        pc_d    = '0;
        valid_d = 1'b0;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    id_io.rs_f_id   = rs_fld;
    id_io.rt_f_id   = rt_fld;
    id_io.rd_f_id   = (cls == WrRd) ? rd_fld : 5'd0;
    id_io.opcode_id = op;
    id_io.pc_id     = pc_q;
    id_io.imm_ext   = {{(32 - IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
    id_io.rs_val    = rs_rdata;
    id_io.rt_val    = rt_rdata;
    id_io.valid_id  = valid_q;
    id_io.halt_id   = (state_q == StHalted);
    id_io.mem_read  = valid_q && (op == OpLdw);
    id_io.mem_write = valid_q && (op == OpStw);
    case (cls)
      WrRd:    id_io.id_dest = rd_fld;
      WrRt:    id_io.id_dest = rt_fld;
      default: id_io.id_dest = 5'd0;
    endcase
    // r0 destinations never raise a hazard in fetch.
    id_io.reg_write_f_id = valid_q && (cls != WrNone) && (id_io.id_dest != 5'd0);
  end

  reg_file #(
    .NREG (NREG)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we_i      (id_io.wb_en),
    .waddr_i   (id_io.wb_dest),
    .wdata_i   (id_io.wb_data),
    .raddr_a_i (rs_fld),
    .raddr_b_i (rt_fld),
    .rdata_a_o (rs_rdata),
    .rdata_b_o (rt_rdata)
  );

endmodule

// File: tb/tb_inst_d.sv
// Self-checking bench for inst_d: directed vector table, hand-written
// reset/bypass sequences, then randomized traffic against a behavioural model.
module tb_inst_d;

`ifdef ID_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_d_if bus ();

  inst_d #(
    .NREG  (32),
    .IMM_W (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .id_io (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        e_valid;
    logic [4:0]  e_dest;
    logic        e_rw;
    logic [31:0] e_rs_val;
    logic [31:0] e_imm;
    logic        e_halt;
    logic        e_mr;
    logic        e_mw;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_halted;

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic stall,
                       input logic flush, input logic wb_en, input logic [4:0] wb_dest,
                       input logic [31:0] wb_data);
    bus.instruction = instr;
    bus.pc_in       = pc;
    bus.stall       = stall;
    bus.flush       = flush;
    bus.wb_en       = wb_en;
    bus.wb_dest     = wb_dest;
    bus.wb_data     = wb_data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid  = 1'b0;
    m_instr  = '0;
    m_pc     = '0;
    m_halted = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (Bypass && bus.wb_en && (bus.wb_dest == a)) return bus.wb_data;
    return m_regs[a];
  endfunction

  task automatic check_model();
    logic [5:0]  op;
    logic        rtype, itype;
    logic [4:0]  rs, rt, rd, dest;
    op    = m_instr[31:26];
    rs    = m_instr[25:21];
    rt    = m_instr[20:16];
    rd    = m_instr[15:11];
    rtype = op inside {6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10};
    itype = op inside {6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd11, 6'd12};
    dest  = rtype ? rd : (itype ? rt : 5'd0);
    chk("rnd_rs_f",   32'(bus.rs_f_id), 32'(rs));
    chk("rnd_rt_f",   32'(bus.rt_f_id), 32'(rt));
    chk("rnd_rd_f",   32'(bus.rd_f_id), 32'(rtype ? rd : 5'd0));
    chk("rnd_dest",   32'(bus.id_dest), 32'(dest));
    chk("rnd_rw",     32'(bus.reg_write_f_id), 32'(m_valid && (rtype || itype) && dest != 0));
    chk("rnd_opcode", 32'(bus.opcode_id), 32'(op));
    chk("rnd_rs_val", bus.rs_val, model_read(rs));
    chk("rnd_rt_val", bus.rt_val, model_read(rt));
    chk("rnd_imm",    bus.imm_ext, {{16{m_instr[15]}}, m_instr[15:0]});
    chk("rnd_pc",     bus.pc_id, m_pc);
    chk("rnd_mr",     32'(bus.mem_read), 32'(m_valid && op == 6'd12));
    chk("rnd_mw",     32'(bus.mem_write), 32'(m_valid && op == 6'd13));
    chk("rnd_valid",  32'(bus.valid_id), 32'(m_valid));
    chk("rnd_halt",   32'(bus.halt_id), 32'(m_halted));
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_valid && m_instr[31:26] == 6'd17) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
      m_instr  = '0;
      m_pc     = '0;
    end else if (bus.flush) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_pc    = '0;
    end else if (!bus.stall) begin
      m_valid = 1'b1;
      m_instr = bus.instruction;
      m_pc    = bus.pc_in;
    end
    if (bus.wb_en && bus.wb_dest != 5'd0) m_regs[bus.wb_dest] = bus.wb_data;
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  op;

    //          instr         st    fl    wb    dst    wdata          v     dest   rw    rs_val         imm            h     mr    mw
    vecs[0]  = '{32'h00221800, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 1'b1, 32'h0,         32'h00001800, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000000, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF,  1'b1, 5'd0, 1'b0, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h04A6FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 1'b1, 32'hDEADBEEF,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 1'b1, 32'hDEADBEEF,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h12345678, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 1'b1, 32'hDEADBEEF,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h30A90008, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 1'b1, 32'hDEADBEEF,  32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h04A6FFFC, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h04000010, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001234,  1'b1, 5'd0, 1'b0, 32'h0,         32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h30A90008, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 32'hDEADBEEF,  32'h00000008, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h34A70004, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b0, 32'hDEADBEEF,  32'h00000004, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'hFC221800, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b0, 32'h0,         32'h00001800, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h44000000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b0, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h00221800, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 32'h0,         32'h0,        1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h04A6FFFC, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 32'h0,         32'h0,        1'b1, 1'b0, 1'b0};

    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_valid", 32'(bus.valid_id), 32'd0);
    chk("rst_halt",  32'(bus.halt_id), 32'd0);
    chk("rst_pc",    bus.pc_id, 32'd0);
    chk("rst_rw",    32'(bus.reg_write_f_id), 32'd0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, 32'h100 + 32'(i * 4), vecs[i].stall, vecs[i].flush, vecs[i].wb_en,
            vecs[i].wb_dest, vecs[i].wb_data);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i),  32'(bus.valid_id), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_dest", i),   32'(bus.id_dest), 32'(vecs[i].e_dest));
      chk($sformatf("v%0d_rw", i),     32'(bus.reg_write_f_id), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_rs_val", i), bus.rs_val, vecs[i].e_rs_val);
      chk($sformatf("v%0d_imm", i),    bus.imm_ext, vecs[i].e_imm);
      chk($sformatf("v%0d_halt", i),   32'(bus.halt_id), 32'(vecs[i].e_halt));
      chk($sformatf("v%0d_mr", i),     32'(bus.mem_read), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d_mw", i),     32'(bus.mem_write), 32'(vecs[i].e_mw));
    end

    // Reset while HALTED: outputs clear at once, decode resumes after release
    #2;
    rst = 1'b0;
    #1;
    chk("hrst_halt",  32'(bus.halt_id), 32'd0);
    chk("hrst_valid", 32'(bus.valid_id), 32'd0);
    chk("hrst_imm",   bus.imm_ext, 32'd0);
    rst = 1'b1;
    drive(32'h00221800, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("resume_valid", 32'(bus.valid_id), 32'd1);
    chk("resume_rs",    32'(bus.rs_f_id), 32'd1);
    chk("resume_rt",    32'(bus.rt_f_id), 32'd2);
    chk("resume_rd",    32'(bus.rd_f_id), 32'd3);
    chk("resume_dest",  32'(bus.id_dest), 32'd3);
    chk("resume_rw",    32'(bus.reg_write_f_id), 32'd1);
    chk("resume_pc",    bus.pc_id, 32'h200);
    chk("resume_halt",  32'(bus.halt_id), 32'd0);

    // Same-cycle write/read of r7, then stall + write-back together
    drive(32'h34070000, 32'h204, 1'b0, 1'b0, 1'b1, 5'd7, 32'h11);
    @(posedge clk);
    #1;
    chk("byp_pre_rt", bus.rt_val, 32'h11);
    drive(32'h00221800, 32'h208, 1'b1, 1'b0, 1'b1, 5'd7, 32'h55);
    #1;
    chk("byp_same_cycle", bus.rt_val, Bypass ? 32'h55 : 32'h11);
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    #1;
    chk("byp_stall_reread", bus.rt_val, 32'h55);
    chk("byp_stall_mw",     32'(bus.mem_write), 32'd1);
    chk("byp_stall_pc",     bus.pc_id, 32'h204);

    // Reset asserted mid-stall empties the slot
    rst = 1'b0;
    #1;
    chk("srst_valid", 32'(bus.valid_id), 32'd0);
    chk("srst_mw",    32'(bus.mem_write), 32'd0);
    chk("srst_rt",    bus.rt_val, 32'd0);
    rst = 1'b1;
    model_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      r = $urandom();
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[15:0]}, $urandom(),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom());
      @(negedge clk);
      check_model();
      if (m_halted && $urandom_range(0, 3) == 0) begin
        rst = 1'b0;
        #1;
        chk("rnd_rst_halt", 32'(bus.halt_id), 32'd0);
        rst = 1'b1;
        model_reset();
      end
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
